// File: rtl/latch_bank_pkg.sv
// Shared types and default sizing for the latch bank sequencer.
package latch_bank_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD,
    CLR
  } lb_state_e;

  localparam int N_LANES_DEF  = 8;
  localparam int W_DEF        = 8;
  localparam int OPEN_CYC_DEF = 2;

endpackage

// File: rtl/latch_bank_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo N.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int               k;
  logic [IDX_W-1:0] k_idx;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    k_idx = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      k_idx = IDX_W'(k);
      if (!valid && req[k_idx]) begin
        valid      = 1'b1;
        gnt[k_idx] = 1'b1;
        idx        = k_idx;
      end
    end
  end

endmodule

// File: rtl/latch_bank_sched.sv
// Sequences setup/open/hold write phases and bank-wide clears for a bank of
// level-sensitive latches sharing one data bus; every output is registered.
module latch_bank_sched
  import latch_bank_pkg::*;
#(
  parameter int  N_LANES  = N_LANES_DEF,
  parameter int  W        = W_DEF,
  parameter int  OPEN_CYC = OPEN_CYC_DEF,
  localparam int IDX_W    = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic [N_LANES-1:0]   i_req,
  input  logic [N_LANES*W-1:0] i_wdata,
  input  logic                 i_clr,
  output logic [N_LANES-1:0]   o_ack,
  output logic                 o_busy,
  output logic [N_LANES-1:0]   o_en,
  output logic [W-1:0]         o_d,
  output logic                 o_lat_rst,
  output logic [IDX_W-1:0]     o_gnt_idx
);

  localparam logic [3:0] CNT_LOAD = 4'(OPEN_CYC - 1);

  lb_state_e          state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               clr_sticky_q, clr_sticky_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_LANES-1:0] gnt_oh_q, gnt_oh_d;
  logic [IDX_W-1:0]   gnt_idx_d;
  logic [W-1:0]       d_d;
  logic [N_LANES-1:0] en_d, ack_d;
  logic               busy_d, lat_rst_d;

  logic [N_LANES-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [W-1:0]       wdata_sel;

  rr_arbiter #(.N(N_LANES), .IDX_W(IDX_W)) u_arb (
    .req   (i_req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    wdata_sel = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (arb_idx == IDX_W'(i)) wdata_sel = i_wdata[i*W +: W];
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clr_sticky_d = clr_sticky_q;
    ptr_d        = ptr_q;
    gnt_oh_d     = gnt_oh_q;
    gnt_idx_d    = o_gnt_idx;
    d_d          = o_d;

    if (i_clr && (state_q == SETUP || state_q == OPEN || state_q == HOLD))
      clr_sticky_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (i_clr || clr_sticky_q) begin
          state_d = CLR;
          cnt_d   = CNT_LOAD;
        end else if (arb_valid) begin
          state_d   = SETUP;
          gnt_oh_d  = arb_gnt;
          gnt_idx_d = arb_idx;
          d_d       = wdata_sel;
          ptr_d     = (arb_idx == IDX_W'(N_LANES - 1)) ? '0 : arb_idx + IDX_W'(1);
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = CNT_LOAD;
      end
      OPEN: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - 4'd1;
      end
      HOLD: state_d = IDLE;
      CLR: begin
        if (cnt_q == '0) begin
          state_d      = IDLE;
          clr_sticky_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    en_d      = (state_d == OPEN) ? gnt_oh_d : '0;
    ack_d     = (state_d == HOLD) ? gnt_oh_d : '0;
    lat_rst_d = (state_d == CLR);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt_q        <= '0;
      clr_sticky_q <= 1'b0;
      ptr_q        <= '0;
      gnt_oh_q     <= '0;
      o_gnt_idx    <= '0;
      o_d          <= '0;
      o_en         <= '0;
      o_ack        <= '0;
      o_lat_rst    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      clr_sticky_q <= clr_sticky_d;
      ptr_q        <= ptr_d;
      gnt_oh_q     <= gnt_oh_d;
      o_gnt_idx    <= gnt_idx_d;
      o_d          <= d_d;
      o_en         <= en_d;
      o_ack        <= ack_d;
      o_lat_rst    <= lat_rst_d;
      o_busy       <= busy_d;
    end
  end

endmodule

// File: doc/latch_bank_sched.md
# latch_bank_sched

Sequencer and round-robin arbiter for a bank of `N_LANES` level-sensitive latch lanes. Each lane is an asynchronously reset latch with an enable and a data input. The block shares one data bus across the lanes and drives a one-hot latch enable per lane. It enforces setup, open and hold phases so data never changes while any latch is transparent. It sits between the register-write requesters and the latch bank, and also sequences bank-wide clears.

## Interface
Parameters:
- `N_LANES`, 8, number of latch lanes and requesters.
- `W`, 8, data width per lane.
- `OPEN_CYC`, 2, cycles the selected latch enable stays high; legal range 1..15.

Ports:
- `i_clk`, in, 1, single clock. Decided: one clock.
- `i_arst_n`, in, 1, reset. Decided: asynchronous, active-low.
- `i_req`, in, N_LANES, per-requester write request; level, held until acked.
- `i_wdata`, in, N_LANES×W, packed write data; slice i belongs to requester i.
- `i_clr`, in, 1, single-cycle pulse requesting a clear of all lanes.
- `o_ack`, out, N_LANES, one-hot, one-cycle write acknowledge.
- `o_busy`, out, 1, high whenever state ≠ IDLE.
- `o_en`, out, N_LANES, one-hot latch enable to the bank.
- `o_d`, out, W, shared latch data bus.
- `o_lat_rst`, out, 1, bank-wide latch reset, active-high.
- `o_gnt_idx`, out, clog2(N_LANES), index of the current or most recent grant.

## Operation
FSM states: IDLE, SETUP, OPEN, HOLD, CLR.

**IDLE**
- A pending clear has priority over requests; it is either `i_clr` in this cycle or the sticky clear flag.
- If a clear is pending, go to CLR.
- Otherwise, if any `i_req` bit is set, the round-robin arbiter picks winner g. Capture g into `o_gnt_idx`, register `i_wdata[g]`, and go to SETUP.

**Data phases**
- SETUP: `o_d` = captured data; `o_en` = 0. Lasts 1 cycle, then OPEN.
- OPEN: `o_en[g]` = 1 for exactly `OPEN_CYC` cycles, counted by a down-counter; then HOLD.
- HOLD: `o_en` = 0, `o_d` unchanged, `o_ack[g]` = 1. Lasts 1 cycle, then IDLE.

**CLR**
- `o_lat_rst` = 1 for `OPEN_CYC` cycles; `o_en` = 0.
- Clears the sticky clear flag, then goes to IDLE.

**Data bus and arbitration**
- `o_d` changes only on the IDLE→SETUP transition. It holds its value at all other times, including across IDLE.
- Round-robin: after a grant to g, priority order becomes g+1, g+2, …, wrapping modulo N_LANES.
- The pointer is unchanged by CLR.

**Boundary rules**
- If `i_clr` arrives while busy, set the sticky flag; it is serviced at the next IDLE, ahead of any request. Multiple pulses collapse into one clear.
- If `i_req[g]` drops mid-transaction, the transaction still completes and acks.
- `i_wdata` changes after capture are ignored.
- A requester whose req is still high in the cycle after its ack is treated as a new request.
- Simultaneous `i_clr` and `i_req` in IDLE: CLR runs first, and the request waits.
- Asynchronous reset mid-operation: all outputs drop immediately; no ack is issued for the aborted write.

## Timing
- Reset values: state IDLE, pointer 0, sticky flag 0. `o_ack`, `o_busy`, `o_en`, `o_d`, `o_lat_rst` and `o_gnt_idx` are all 0.
- All outputs are registered.
- Write, with the request seen in IDLE at cycle t:
  - SETUP at t+1.
  - `o_en` high from t+2 through t+1+OPEN_CYC.
  - HOLD/ack at t+2+OPEN_CYC.
  - IDLE at t+3+OPEN_CYC.
- Sustained throughput is one write per 3+OPEN_CYC cycles.
- Clear seen in IDLE at t: `o_lat_rst` high from t+1 through t+OPEN_CYC; IDLE at t+1+OPEN_CYC.
- Invariants:
  - `o_en` is at most one-hot.
  - `o_en` and `o_lat_rst` are never high together.
  - `o_d` is stable for at least 1 cycle on each side of any `o_en` high window.

## Structure
- Shared package `latch_bank_pkg`: the state enum `lb_state_e` (IDLE, SETUP, OPEN, HOLD, CLR) and default constants for `N_LANES`, `W` and `OPEN_CYC`.
- One sub-module, `rr_arbiter`. It is combinational: inputs are the request vector and the pointer; outputs are one-hot grant plus index. The pointer register lives in `latch_bank_sched`.
- The top block holds the FSM, the OPEN/CLR counter, the sticky clear flag and the output registers.

## Test plan
- Reset: hold `i_arst_n`=0 with `i_req`=8'hFF → every output is 0. Release → grant to lane 0 first; `o_gnt_idx`=0.
- Single write: `i_req`=8'h08, `i_wdata[3]`=8'hA5, `OPEN_CYC`=2 → SETUP at t+1. `o_en`=8'h08 at t+2 and t+3. `o_ack`=8'h08 at t+4. `o_d`=8'hA5 from t+1 and unchanged afterwards.
- Round-robin: hold `i_req`=8'hFF → grant order 0,1,…,7,0. The spacing between acks is 5 cycles.
- Clear priority: `i_clr` and `i_req`=8'h01 in the same IDLE cycle → `o_lat_rst` high for 2 cycles, then the write to lane 0.
- Clear while busy: pulse `i_clr` twice during OPEN → exactly one CLR window, starting the cycle after HOLD's following IDLE.
- Reset mid-OPEN: assert `i_arst_n`=0 while `o_en`=8'h04 → `o_en` is 0 immediately and no ack occurs. After release, lane 2 is re-arbitrated from pointer 0.
